program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 172 +++++++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
// Streams bytes into instruction words and burns them into the processor's
// instruction RAM, holding the processor in reset for the whole load.
//
// Ports:
//   Clk            - single clock, rising edge
//   Reset          - asynchronous, active-low reset
//   Load_Start     - begin a load (honoured only when idle)
//   Load_Base      - first instruction address, captured with Load_Start
//   Load_Count     - number of words to load, captured with Load_Start
//   Byte_In        - stream byte
//   Byte_Valid     - qualifies Byte_In
//   Byte_Ready     - loader accepts a byte this cycle
//   Ram_Inst_Write - one-cycle burn strobe
//   Inst_Addr      - burn address (holds outside the strobe)
//   Ram_Inst_In    - burn data, first byte in the MSBs (holds outside the strobe)
//   Proc_Reset     - active-high hold for the processor reset input
//   Busy           - loader is not idle
//   Load_Done      - one-cycle completion pulse
module program_loader #(
    parameter int INST_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Load_Start,
    input  logic [ADDR_WIDTH-1:0] Load_Base,
    input  logic [ADDR_WIDTH:0]   Load_Count,
    input  logic [7:0]            Byte_In,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    output logic                  Ram_Inst_Write,
    output logic [ADDR_WIDTH-1:0] Inst_Addr,
    output logic [INST_WIDTH-1:0] Ram_Inst_In,
    output logic                  Proc_Reset,
    output logic                  Busy,
    output logic                  Load_Done
);

    localparam int BYTES = INST_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_COUNT = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH:0]   remain_r;
    logic [IDX_W-1:0]      idx_r;
    logic [INST_WIDTH-1:0] word_r;
    logic [ADDR_WIDTH:0]   count_clamp_s;
    logic [INST_WIDTH-1:0] byte_ext_s;
    logic [INST_WIDTH-1:0] word_shift_s;
    logic                  byte_xfer_s;

    // Datapath helpers: clamped count, MSB-first word assembly, handshake.
    always_comb begin
        count_clamp_s = Load_Count;
        // Counts above the RAM depth are limited to one full pass of the RAM.
        if (Load_Count[ADDR_WIDTH]) begin
            count_clamp_s = MAX_COUNT;
        end else begin
            count_clamp_s = Load_Count;
        end
        byte_ext_s      = '0;
        byte_ext_s[7:0] = Byte_In;
        // Older bytes move up; after BYTES shifts the first byte sits in the MSBs.
        word_shift_s    = (word_r << 4'd8) | byte_ext_s;
        byte_xfer_s     = Byte_Valid & Byte_Ready;
    end

    // Next-state decode for the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (Load_Start) begin
                    if (count_clamp_s == '0) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = COLLECT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (byte_xfer_s && (idx_r == LAST_IDX)) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            WRITE: begin
                if (remain_r == ONE_COUNT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, counters and registered outputs (outputs decoded from next state).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r        <= IDLE;
            addr_r         <= '0;
            remain_r       <= '0;
            idx_r          <= '0;
            word_r         <= '0;
            Byte_Ready     <= 1'b0;
            Ram_Inst_Write <= 1'b0;
            Inst_Addr      <= '0;
            Ram_Inst_In    <= '0;
            Proc_Reset     <= 1'b1;
            Busy           <= 1'b0;
            Load_Done      <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            Byte_Ready     <= (state_next_s == COLLECT);
            Ram_Inst_Write <= (state_next_s == WRITE);
            Load_Done      <= (state_next_s == DONE);
            Busy           <= (state_next_s != IDLE);
            Proc_Reset     <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (Load_Start) begin
                        addr_r   <= Load_Base;
                        remain_r <= count_clamp_s;
                        idx_r    <= '0;
                    end
                end
                COLLECT: begin
                    if (byte_xfer_s) begin
                        word_r <= word_shift_s;
                        if (idx_r == LAST_IDX) begin
                            // Burn address/data are latched here and then held.
                            idx_r       <= '0;
                            Inst_Addr   <= addr_r;
                            Ram_Inst_In <= word_shift_s;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                WRITE: begin
                    addr_r   <= addr_r + ADDR_WIDTH'(1);
                    remain_r <= remain_r - ONE_COUNT;
                    idx_r    <= '0;
                end
                DONE: begin
                    idx_r <= '0;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Load_Start = 1'b0;
    logic [7:0]  Load_Base = 8'h00;
    logic [8:0]  Load_Count = 9'd0;
    logic [7:0]  Byte_In = 8'h00;
    logic        Byte_Valid = 1'b0;
    logic        Byte_Ready;
    logic        Ram_Inst_Write;
    logic [7:0]  Inst_Addr;
    logic [15:0] Ram_Inst_In;
    logic        Proc_Reset;
    logic        Busy;
    logic        Load_Done;

    program_loader #(.INST_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Load_Start(Load_Start), .Load_Base(Load_Base),
        .Load_Count(Load_Count), .Byte_In(Byte_In), .Byte_Valid(Byte_Valid),
        .Byte_Ready(Byte_Ready), .Ram_Inst_Write(Ram_Inst_Write), .Inst_Addr(Inst_Addr),
        .Ram_Inst_In(Ram_Inst_In), .Proc_Reset(Proc_Reset), .Busy(Busy), .Load_Done(Load_Done)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fails = 0;

    // Reference stream and observed burns.
    logic [7:0]  stream_b [0:1023];
    logic [7:0]  obs_a [$];
    logic [15:0] obs_d [$];
    int          done_pulses;
    int          done_cycle;
    int          overlap;
    bit          timed_out;
    logic        proc_at_done;
    logic        proc_after;
    logic        busy_after;

    task automatic fill_stream();
        for (int i = 0; i < 1024; i++) stream_b[i] = 8'($urandom);
    endtask

    // Drives one load from stream_b and records everything the DUT does.
    task automatic run_load(input logic [7:0] base, input logic [8:0] count,
                            input int valid_pct, input bit inject, input int n_bytes);
        int p;
        int cyc;
        bit finished;
        obs_a.delete();
        obs_d.delete();
        done_pulses = 0; done_cycle = -1; overlap = 0;
        proc_at_done = 1'bx; proc_after = 1'bx; busy_after = 1'bx;
        p = 0; cyc = 0; finished = 1'b0;
        @(negedge Clk);
        Load_Start = 1'b1; Load_Base = base; Load_Count = count; Byte_Valid = 1'b0;
        while (!finished && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            if (Ram_Inst_Write) begin
                obs_a.push_back(Inst_Addr);
                obs_d.push_back(Ram_Inst_In);
            end
            if (Ram_Inst_Write && Load_Done) overlap++;
            if (Load_Done) begin
                done_pulses++;
                if (done_cycle < 0) begin
                    done_cycle = cyc;
                    proc_at_done = Proc_Reset;
                end
            end
            if (done_cycle >= 0 && cyc == done_cycle + 1) begin
                proc_after = Proc_Reset;
                busy_after = Busy;
            end
            if (done_cycle >= 0 && cyc == done_cycle + 3) finished = 1'b1;
            Load_Start = inject && Busy && !Load_Done && ($urandom_range(1) == 1);
            Load_Base  = ~base;
            Load_Count = 9'($urandom_range(1, 5));
            if (Byte_Ready && p < n_bytes && ($urandom_range(99) < valid_pct)) begin
                Byte_Valid = 1'b1; Byte_In = stream_b[p]; p++;
            end else if (!Byte_Ready) begin
                Byte_Valid = 1'($urandom_range(1)); Byte_In = 8'($urandom);
            end else begin
                Byte_Valid = 1'b0; Byte_In = 8'($urandom);
            end
        end
        timed_out = !finished;
        Load_Start = 1'b0;
        Byte_Valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b0;
        #1;
        n_tests++;
        if ({Byte_Ready, Ram_Inst_Write, Inst_Addr, Ram_Inst_In, Busy, Load_Done, Proc_Reset} !==
            {1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL reset_values: got rdy=%b wr=%b a=%h d=%h busy=%b done=%b pr=%b want 0 0 00 0000 0 0 1",
                     Byte_Ready, Ram_Inst_Write, Inst_Addr, Ram_Inst_In, Busy, Load_Done, Proc_Reset);
        end
        @(negedge Clk);
        n_tests++;
        if (Proc_Reset !== 1'b1) begin
            n_fails++; $display("FAIL reset_hold_proc: got %b want 1", Proc_Reset);
        end
        Reset = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (Proc_Reset !== 1'b0 || Busy !== 1'b0 || Byte_Ready !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: got pr=%b busy=%b rdy=%b want 0 0 0", Proc_Reset, Busy, Byte_Ready);
        end
    endtask

    task automatic test_basic(input int valid_pct, input bit inject, input string tag);
        logic [7:0]  exp_a;
        logic [15:0] exp_d;
        stream_b[0] = 8'h12; stream_b[1] = 8'h34; stream_b[2] = 8'h56; stream_b[3] = 8'h78;
        run_load(8'h10, 9'd2, valid_pct, inject, 4);
        n_tests++;
        if (timed_out || obs_a.size() != 2) begin
            n_fails++; $display("FAIL %s_writes: got %0d writes (timeout=%0d) want 2", tag, obs_a.size(), timed_out);
        end
        for (int i = 0; i < 2 && i < obs_a.size(); i++) begin
            exp_a = 8'h10 + 8'(i);
            exp_d = (i == 0) ? 16'h1234 : 16'h5678;
            n_tests++;
            if (obs_a[i] !== exp_a || obs_d[i] !== exp_d) begin
                n_fails++; $display("FAIL %s_word%0d: got %h@%h want %h@%h", tag, i, obs_d[i], obs_a[i], exp_d, exp_a);
            end
        end
        n_tests++;
        if (done_pulses != 1 || overlap != 0 || proc_at_done !== 1'b1 || proc_after !== 1'b0 || busy_after !== 1'b0) begin
            n_fails++;
            $display("FAIL %s_done: got pulses=%0d overlap=%0d pr_done=%b pr_after=%b busy_after=%b want 1 0 1 0 0",
                     tag, done_pulses, overlap, proc_at_done, proc_after, busy_after);
        end
        n_tests++;
        if (Inst_Addr !== 8'h11 || Ram_Inst_In !== 16'h5678 || Ram_Inst_Write !== 1'b0) begin
            n_fails++; $display("FAIL %s_hold: got %h@%h wr=%b want 5678@11 wr=0", tag, Ram_Inst_In, Inst_Addr, Ram_Inst_Write);
        end
    endtask

    task automatic test_count_zero();
        run_load(8'h42, 9'd0, 100, 1'b0, 0);
        n_tests++;
        if (timed_out || done_cycle != 1 || done_pulses != 1 || obs_a.size() != 0) begin
            n_fails++;
            $display("FAIL count_zero: got done_cycle=%0d pulses=%0d writes=%0d want 1 1 0", done_cycle, done_pulses, obs_a.size());
        end
        n_tests++;
        if (proc_after !== 1'b0 || busy_after !== 1'b0) begin
            n_fails++; $display("FAIL count_zero_idle: got pr=%b busy=%b want 0 0", proc_after, busy_after);
        end
    endtask

    // Random bytes, random base/count; expected burns come from plain arithmetic.
    task automatic test_random_loads(input logic [7:0] base, input logic [8:0] count,
                                     input int valid_pct, input bit inject, input string tag);
        int          n_words;
        logic [7:0]  exp_a;
        logic [15:0] exp_d;
        int          bad;
        fill_stream();
        n_words = (count > 9'd256) ? 256 : int'(count);
        run_load(base, count, valid_pct, inject, 2 * n_words);
        n_tests++;
        if (timed_out || obs_a.size() != n_words) begin
            n_fails++; $display("FAIL %s_writes: got %0d (timeout=%0d) want %0d", tag, obs_a.size(), timed_out, n_words);
        end
        bad = 0;
        for (int i = 0; i < n_words && i < obs_a.size(); i++) begin
            exp_a = base + 8'(i);
            exp_d = {stream_b[2 * i], stream_b[2 * i + 1]};
            if (obs_a[i] !== exp_a || obs_d[i] !== exp_d) begin
                if (bad == 0) $display("FAIL %s_word%0d: got %h@%h want %h@%h", tag, i, obs_d[i], obs_a[i], exp_d, exp_a);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fails++;
        n_tests++;
        if (done_pulses != 1 || overlap != 0 || proc_after !== 1'b0) begin
            n_fails++; $display("FAIL %s_done: got pulses=%0d overlap=%0d pr_after=%b want 1 0 0", tag, done_pulses, overlap, proc_after);
        end
    endtask

    task automatic test_reset_midload();
        int wr;
        int bad;
        @(negedge Clk);
        Load_Start = 1'b1; Load_Base = 8'h20; Load_Count = 9'd2; Byte_Valid = 1'b0;
        @(negedge Clk);
        Load_Start = 1'b0; Byte_Valid = 1'b1; Byte_In = 8'hAB;
        n_tests++;
        if (Byte_Ready !== 1'b1) begin
            n_fails++; $display("FAIL midload_ready: got %b want 1", Byte_Ready);
        end
        @(negedge Clk);
        Byte_Valid = 1'b0;
        #2 Reset = 1'b0;
        #1;
        n_tests++;
        if ({Byte_Ready, Ram_Inst_Write, Inst_Addr, Ram_Inst_In, Busy, Load_Done, Proc_Reset} !==
            {1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL midload_reset_values: got rdy=%b wr=%b a=%h d=%h busy=%b done=%b pr=%b want 0 0 00 0000 0 0 1",
                     Byte_Ready, Ram_Inst_Write, Inst_Addr, Ram_Inst_In, Busy, Load_Done, Proc_Reset);
        end
        wr = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Ram_Inst_Write) wr++;
        end
        Reset = 1'b1;
        bad = 0;
        // Bytes offered without a new Load_Start must be ignored.
        repeat (4) begin
            Byte_Valid = 1'b1; Byte_In = 8'($urandom);
            @(negedge Clk);
            if (Ram_Inst_Write) wr++;
            if (Byte_Ready || Busy || Proc_Reset) bad++;
        end
        Byte_Valid = 1'b0;
        n_tests++;
        if (wr != 0 || bad != 0) begin
            n_fails++; $display("FAIL midload_no_write: got writes=%0d busy_cycles=%0d want 0 0", wr, bad);
        end
        test_random_loads(8'h30, 9'd2, 100, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic(100, 1'b0, "basic");
        test_count_zero();
        test_random_loads(8'hFF, 9'd2, 70, 1'b0, "wrap");
        test_basic(40, 1'b0, "valid_toggle");
        test_basic(60, 1'b1, "start_ignored");
        test_reset_midload();
        test_random_loads(8'($urandom), 9'h1FF, 100, 1'b0, "clamp");
        for (int k = 0; k < 6; k++) begin
            test_random_loads(8'($urandom), 9'($urandom_range(1, 8)), int'($urandom_range(30, 100)),
                              1'($urandom_range(1)), "random");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
